fifo_rd_ctrl: RTL and testbench

Read-domain controller for the async FIFO. It holds the binary/Gray read pointer, synchronises the write-domain Gray pointer with 2 flops, and generates r_empty. It drives r_addr/r_inc into the dual-port memory, whose read port is combinational (FWFT). A one-entry registered output stage presents the read data downstream over a valid/ready handshake.

---
 rtl/fifo_rd_ctrl_if.sv | 61 ++++++
 rtl/fifo_rd_ctrl.sv | 119 +++++++++++
 tb/tb_fifo_rd_ctrl.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_ctrl_if.sv
// -----------------------------------------------------------------------------
// fifo_rd_ctrl_if
// Bundles the read-domain signals of the async FIFO read controller: the
// write-pointer input from the write domain, the memory read port and the
// downstream valid/ready output stage.
//
// Signals:
//   r_wptr_gray  write pointer, Gray-coded, asynchronous to r_clk
//   r_data_in    combinational read data from memory at r_addr
//   r_ready      downstream accepts r_data_out this cycle
//   r_addr       memory read address
//   r_inc        pop strobe to memory
//   r_empty      FIFO empty as seen by the read domain
//   r_ptr_gray   registered Gray read pointer for the write-domain synchroniser
//   r_valid      r_data_out holds a valid word
//   r_data_out   registered output word
//   r_level      occupancy estimate (only with FIFO_RD_LEVEL_EN defined)
//
// Modports:
//   master  the read controller (drives address, strobe, status, output word)
//   slave   the surrounding memory / write domain / downstream consumer
//
// Optional macro: FIFO_RD_LEVEL_EN adds r_level.
// -----------------------------------------------------------------------------
interface fifo_rd_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic [ADDR_WIDTH:0]   r_wptr_gray;
    logic [DATA_WIDTH-1:0] r_data_in;
    logic                  r_ready;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_inc;
    logic                  r_empty;
    logic [ADDR_WIDTH:0]   r_ptr_gray;
    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data_out;
`ifdef FIFO_RD_LEVEL_EN
    logic [ADDR_WIDTH:0]   r_level;

    modport master (
        input  r_wptr_gray, r_data_in, r_ready,
        output r_addr, r_inc, r_empty, r_ptr_gray, r_valid, r_data_out, r_level
    );

    modport slave (
        output r_wptr_gray, r_data_in, r_ready,
        input  r_addr, r_inc, r_empty, r_ptr_gray, r_valid, r_data_out, r_level
    );
`else
    modport master (
        input  r_wptr_gray, r_data_in, r_ready,
        output r_addr, r_inc, r_empty, r_ptr_gray, r_valid, r_data_out
    );

    modport slave (
        output r_wptr_gray, r_data_in, r_ready,
        input  r_addr, r_inc, r_empty, r_ptr_gray, r_valid, r_data_out
    );
`endif
endinterface

// File: rtl/fifo_rd_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_rd_ctrl
// Read-domain controller of an async FIFO. Keeps the binary/Gray read
// pointer, brings the write-domain Gray pointer across with a 2-flop
// synchroniser, generates the registered empty flag and drives the address
// and pop strobe of a first-word-fall-through memory. A one-entry registered
// output stage hands words downstream.
//
// Ports:
//   r_clk    read-domain clock
//   r_rst_n  synchronous active-low reset, sampled on posedge r_clk
//   rd       fifo_rd_ctrl_if.master (see the interface for the signal list)
//
// Handshake: a word moves downstream on a rising edge where r_valid and
// r_ready are both high; while r_valid is high and r_ready is low, r_valid
// and r_data_out hold. An accept and the load of the next word may happen on
// the same edge, giving one word per cycle.
//
// Optional macro: FIFO_RD_LEVEL_EN adds the registered r_level output.
// -----------------------------------------------------------------------------
module fifo_rd_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic            r_clk,
    input  logic            r_rst_n,
    fifo_rd_ctrl_if.master  rd
);

    localparam int PW = ADDR_WIDTH + 1;

    logic [PW-1:0]         rbin_q, rbin_d;
    logic [PW-1:0]         rgray_q, rgray_d;
    logic [PW-1:0]         wq1_q, wq2_q;
    logic                  empty_q, empty_d;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  inc;

    // Pop whenever there is a word and the output stage is free or being
    // emptied this cycle; gating on empty_q makes underflow impossible.
    always_comb begin
        inc     = !empty_q && (!valid_q || rd.r_ready);
        rbin_d  = rbin_q + {{(PW-1){1'b0}}, inc};
        rgray_d = rbin_d ^ (rbin_d >> 1);
        // Full-width Gray compare so the wrap bit keeps empty correct
        // across pointer wrap.
        empty_d = (rgray_d == wq2_q);

        valid_d = valid_q;
        data_d  = data_q;
        if (inc) begin
            data_d  = rd.r_data_in;
            valid_d = 1'b1;
        end else if (rd.r_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge r_clk) begin
        if (!r_rst_n) begin
            rbin_q  <= '0;
            rgray_q <= '0;
            wq1_q   <= '0;
            wq2_q   <= '0;
            empty_q <= 1'b1;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            // Plain two-flop synchroniser, nothing between the stages.
            wq1_q   <= rd.r_wptr_gray;
            wq2_q   <= wq1_q;
            rbin_q  <= rbin_d;
            rgray_q <= rgray_d;
            empty_q <= empty_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign rd.r_addr     = rbin_q[ADDR_WIDTH-1:0];
    assign rd.r_inc      = inc;
    assign rd.r_empty    = empty_q;
    assign rd.r_ptr_gray = rgray_q;
    assign rd.r_valid    = valid_q;
    assign rd.r_data_out = data_q;

`ifdef FIFO_RD_LEVEL_EN
    logic [PW-1:0] wbin_sync;
    logic [PW-1:0] level_q, level_d;

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Uses the synchronised write pointer, so the estimate can lag writes
    // but never counts a word the read side cannot yet see.
    always_comb begin
        wbin_sync = gray2bin(wq2_q);
        level_d   = wbin_sync - rbin_d;
    end

    always_ff @(posedge r_clk) begin
        if (!r_rst_n) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

    assign rd.r_level = level_q;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_ctrl
// Bench for fifo_rd_ctrl. Models the write side (memory array plus binary
// write pointer), drives r_ready, and scores the delivered words against an
// expected queue filled at write time.
// -----------------------------------------------------------------------------
module tb_fifo_rd_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fifo_rd_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) vif ();

    fifo_rd_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .r_clk   (clk),
        .r_rst_n (rst_n),
        .rd      (vif.master)
    );

    // ---------------- write-side model ----------------
    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wbin;
    logic [AW:0]   rb_model;
    logic [DW-1:0] exp_q [$];
    int            n_checks;
    int            n_errors;

    assign vif.r_data_in = mem[vif.r_addr];

    function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [DW-1:0] d);
        mem[wbin[AW-1:0]] = d;
        wbin              = wbin + 1'b1;
        vif.r_wptr_gray   = bin2gray(wbin);
        exp_q.push_back(d);
    endtask

    task automatic drain(input int budget, input bit rand_ready);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || vif.r_valid) && n < budget) begin
            vif.r_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            n++;
        end
        vif.r_ready = 1'b1;
        check_eq("drain_in_budget", 32'(n < budget), 32'd1);
    endtask

    task automatic wait_valid(input int budget);
        int n;
        n = 0;
        while (!vif.r_valid && n < budget) begin
            tick();
            n++;
        end
        check_eq("valid_in_budget", 32'(n < budget), 32'd1);
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        rb_model = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                rb_model = '0;
            end else begin
                check_eq("r_addr", 32'(vif.r_addr), 32'(rb_model[AW-1:0]));
                check_eq("r_ptr_gray", 32'(vif.r_ptr_gray), 32'(bin2gray(rb_model)));
                check_eq("inc_while_empty", 32'(vif.r_inc & vif.r_empty), 32'd0);
                if (wbin == rb_model) begin
                    check_eq("empty_when_drained", 32'(vif.r_empty), 32'd1);
                end
                if (vif.r_valid && vif.r_ready) begin
                    check_eq("pop_has_expected", 32'(exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0) begin
                        check_eq("data_order", 32'(vif.r_data_out), 32'(exp_q.pop_front()));
                    end
                end
                if (vif.r_inc) begin
                    rb_model = rb_model + 1'b1;
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        n_checks        = 0;
        n_errors        = 0;
        wbin            = '0;
        vif.r_ready     = 1'b0;
        vif.r_wptr_gray = 5'b00011;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;

        // Reset with a nonzero write pointer on the input.
        tick();
        tick();
        check_eq("rst_empty", 32'(vif.r_empty), 32'd1);
        check_eq("rst_valid", 32'(vif.r_valid), 32'd0);
        check_eq("rst_data", 32'(vif.r_data_out), 32'd0);
        check_eq("rst_ptr_gray", 32'(vif.r_ptr_gray), 32'd0);
        check_eq("rst_inc", 32'(vif.r_inc), 32'd0);
        vif.r_wptr_gray = '0;
        vif.r_ready     = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();

        // Single word: pointer latency through the synchroniser.
        push_word(8'hA5);
        tick();
        check_eq("single_empty_e1", 32'(vif.r_empty), 32'd1);
        tick();
        check_eq("single_empty_e2", 32'(vif.r_empty), 32'd1);
        tick();
        check_eq("single_empty_e3", 32'(vif.r_empty), 32'd0);
        check_eq("single_inc_e3", 32'(vif.r_inc), 32'd1);
        tick();
        check_eq("single_valid_e4", 32'(vif.r_valid), 32'd1);
        check_eq("single_data_e4", 32'(vif.r_data_out), 32'hA5);
        check_eq("single_empty_e4", 32'(vif.r_empty), 32'd1);
        check_eq("single_gray_e4", 32'(vif.r_ptr_gray), 32'b00001);
        tick();
        check_eq("single_valid_e5", 32'(vif.r_valid), 32'd0);

        // Backpressure: the first word holds until accepted.
        vif.r_ready = 1'b0;
        push_word(8'h11);
        tick();
        push_word(8'h22);
        tick();
        push_word(8'h33);
        repeat (6) tick();
        check_eq("bp_valid", 32'(vif.r_valid), 32'd1);
        check_eq("bp_data_hold", 32'(vif.r_data_out), 32'h11);
        check_eq("bp_inc", 32'(vif.r_inc), 32'd0);
        vif.r_ready = 1'b1;
        tick();
        check_eq("bp_data_22", 32'(vif.r_data_out), 32'h22);
        check_eq("bp_valid_22", 32'(vif.r_valid), 32'd1);
        tick();
        check_eq("bp_data_33", 32'(vif.r_data_out), 32'h33);
        check_eq("bp_valid_33", 32'(vif.r_valid), 32'd1);
        tick();
        check_eq("bp_valid_end", 32'(vif.r_valid), 32'd0);

        // Wrap: 40 random words in bursts of 16/16/8 with random ready.
        for (int b = 0; b < 3; b++) begin
            int burst;
            burst = (b == 2) ? 8 : 16;
            for (int k = 0; k < burst; k++) begin
                vif.r_ready = 1'($urandom_range(0, 1));
                push_word(8'($urandom_range(0, 255)));
                tick();
            end
            drain(600, 1'b1);
        end
        repeat (3) tick();
        check_eq("wrap_gray_final", 32'(vif.r_ptr_gray), 32'(bin2gray(wbin)));
        check_eq("wrap_empty_final", 32'(vif.r_empty), 32'd1);

        // Reset while a word is waiting on the output.
        vif.r_ready = 1'b0;
        push_word(8'h77);
        tick();
        push_word(8'h88);
        tick();
        push_word(8'h99);
        wait_valid(20);
        rst_n           = 1'b0;
        wbin            = '0;
        vif.r_wptr_gray = '0;
        exp_q.delete();
        tick();
        check_eq("mid_rst_valid", 32'(vif.r_valid), 32'd0);
        check_eq("mid_rst_empty", 32'(vif.r_empty), 32'd1);
        check_eq("mid_rst_addr", 32'(vif.r_addr), 32'd0);
        check_eq("mid_rst_gray", 32'(vif.r_ptr_gray), 32'd0);
        check_eq("mid_rst_data", 32'(vif.r_data_out), 32'd0);
        rst_n = 1'b1;
        tick();
        vif.r_ready = 1'b1;
        push_word(8'h5A);
        tick();
        check_eq("post_rst_empty_e1", 32'(vif.r_empty), 32'd1);
        tick();
        check_eq("post_rst_empty_e2", 32'(vif.r_empty), 32'd1);
        tick();
        check_eq("post_rst_empty_e3", 32'(vif.r_empty), 32'd0);
        push_word(8'hC3);
        drain(50, 1'b0);

`ifdef FIFO_RD_LEVEL_EN
        // Level: one word sits in the output stage, the rest in memory.
        vif.r_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            push_word(8'(k + 8'h40));
            tick();
        end
        repeat (4) tick();
        check_eq("level_after_writes", 32'(vif.r_level), 32'(wbin - rb_model));
        check_eq("level_nine", 32'(vif.r_level), 32'd9);
        vif.r_ready = 1'b1;
        repeat (4) tick();
        vif.r_ready = 1'b0;
        tick();
        check_eq("level_after_reads", 32'(vif.r_level), 32'(wbin - rb_model));
        check_eq("level_five", 32'(vif.r_level), 32'd5);
        drain(100, 1'b0);
`endif

        repeat (3) tick();
        check_eq("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
